// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_stage_pkg;

  localparam int unsigned RegBusW = 64;
  localparam int unsigned InstW   = 32;

  // First fetch address after reset unless the parent overrides RESET_PC.
  localparam logic [RegBusW-1:0] ResetPcDefault = 64'h8000_0000;

  // addi x0, x0, 0: decodes to harmless control while no instruction is live.
  localparam logic [InstW-1:0] InstNop = 32'h0000_0013;

  // Fetch FSM: issue a request, wait for its response, or idle one cycle after a flush.
  typedef enum logic [1:0] {
    IfReq  = 2'd0,
    IfWait = 2'd1,
    IfGap  = 2'd2
  } if_state_e;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [InstW-1:0]   inst;
    logic [RegBusW-1:0] addr;
  } fetch_entry_t;

  // Contents of an empty output slot.
  localparam fetch_entry_t EntryNop = '{inst: InstNop, addr: '0};

  // Instructions are 4-byte aligned; low address bits of a target are ignored.
  function automatic logic [RegBusW-1:0] align_pc(input logic [RegBusW-1:0] pc);
    return {pc[RegBusW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched instruction while decode stalls.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_valid,
  output fetch_entry_t o_entry
);

  logic         r_valid;
  fetch_entry_t r_entry;

  // Flush wins over push, push wins over pop; the stage never pushes into a full buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_entry <= EntryNop;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one memory request in flight and
// hands instructions to decode through a registered output slot backed by a skid buffer.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction memory port
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // Control-flow redirect from downstream
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  // Decode interface
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_addr
);

  // Architectural state
  if_state_e    r_state;
  logic [63:0]  r_pc;
  logic [63:0]  r_req_addr;
  logic         r_drop;
  fetch_entry_t r_out;
  logic         r_out_valid;

  // Next-state values
  if_state_e    w_state_next;
  logic [63:0]  w_pc_next;
  logic [63:0]  w_req_addr_next;
  logic         w_drop_next;
  fetch_entry_t w_out_next;
  logic         w_out_valid_next;

  // Skid buffer control and status
  logic         w_sb_push;
  logic         w_sb_pop;
  logic         w_sb_flush;
  logic         w_sb_valid;
  fetch_entry_t w_sb_entry;

  // Per-cycle events
  logic         w_grant;
  logic         w_rsp;
  logic         w_rsp_live;
  logic         w_out_free;
  fetch_entry_t w_rsp_entry;

  // A full skid buffer stalls fetch so no more than two instructions are ever buffered.
  // Holding the request low during reset keeps a grant from racing the reset.
  assign imem_req  = (r_state == IfReq) && !w_sb_valid && !rst;
  assign imem_addr = r_pc;

  assign w_grant     = imem_req && imem_gnt;
  assign w_rsp       = (r_state == IfWait) && imem_rvalid;
  assign w_rsp_live  = w_rsp && !r_drop;
  assign w_rsp_entry = '{inst: imem_rdata, addr: r_req_addr};

  // The output slot can take new data when it is empty or being consumed this cycle.
  assign w_out_free = !r_out_valid || id_ready;

  // Fetch FSM: next state, PC, outstanding-request address and drop flag.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_req_addr_next = r_req_addr;
    w_drop_next     = r_drop;

    if (redirect_valid) begin
      w_pc_next = align_pc(redirect_pc);
      unique case (r_state)
        IfReq: begin
          if (w_grant) begin
            // The request just issued belongs to the old path; its response is discarded.
            w_req_addr_next = r_pc;
            w_drop_next     = 1'b1;
            w_state_next    = IfWait;
          end else begin
            // Retract the request for one cycle so the address never moves under it.
            w_state_next = IfGap;
          end
        end
        IfWait: begin
          if (imem_rvalid) begin
            w_drop_next  = 1'b0;
            w_state_next = IfReq;
          end else begin
            w_drop_next = 1'b1;
          end
        end
        IfGap: begin
          w_state_next = IfReq;
        end
        default: begin
          w_state_next = IfReq;
        end
      endcase
    end else begin
      unique case (r_state)
        IfReq: begin
          if (w_grant) begin
            w_req_addr_next = r_pc;
            w_pc_next       = r_pc + 64'd4;
            w_state_next    = IfWait;
          end
        end
        IfWait: begin
          if (imem_rvalid) begin
            w_drop_next  = 1'b0;
            w_state_next = IfReq;
          end
        end
        IfGap: begin
          w_state_next = IfReq;
        end
        default: begin
          w_state_next = IfReq;
        end
      endcase
    end
  end

  // Output slot and skid buffer steering: buffered data drains before a fresh response.
  always_comb begin
    w_out_next       = r_out;
    w_out_valid_next = r_out_valid;
    w_sb_push        = 1'b0;
    w_sb_pop         = 1'b0;
    w_sb_flush       = 1'b0;

    if (redirect_valid) begin
      // Anything consumed this cycle already left; everything else is on the wrong path.
      w_out_valid_next = 1'b0;
      w_sb_flush       = 1'b1;
    end else if (w_out_free) begin
      if (w_sb_valid) begin
        w_out_next       = w_sb_entry;
        w_out_valid_next = 1'b1;
        w_sb_pop         = 1'b1;
      end else if (w_rsp_live) begin
        w_out_next       = w_rsp_entry;
        w_out_valid_next = 1'b1;
      end else begin
        w_out_valid_next = 1'b0;
      end
    end else if (w_rsp_live) begin
      w_sb_push = 1'b1;
    end

    // An empty slot always shows a NOP at address 0 to decode.
    if (!w_out_valid_next) begin
      w_out_next = EntryNop;
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IfReq;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_req_addr <= w_req_addr_next;
      r_drop     <= w_drop_next;
    end
  end

  // Output register presented to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= EntryNop;
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= w_out_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  if_skid_buf u_skid_buf (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_sb_push),
    .i_entry (w_rsp_entry),
    .i_pop   (w_sb_pop),
    .i_flush (w_sb_flush),
    .o_valid (w_sb_valid),
    .o_entry (w_sb_entry)
  );

  assign inst_valid = r_out_valid;
  assign inst       = r_out.inst;
  assign inst_addr  = r_out.addr;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a cycle table for the directed cases, then random traffic checked
// against the expected instruction stream (sequential PCs restarted at each redirect).
module tb_if_stage;

  localparam logic [63:0] ResetPc = 64'h8000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [63:0] A       = 64'h8000_0000;
  localparam logic [63:0] B       = 64'h8000_0100;
  localparam logic [63:0] C       = 64'h8000_0200;
  localparam logic [63:0] W       = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: single outstanding request.
  logic        pend_valid = 1'b0;
  logic [63:0] pend_addr  = '0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(ResetPc)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_addr      (inst_addr)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive the memory port for the coming edge and track the outstanding request.
  task automatic mem_drive(input logic gnt_ok, input logic rsp_ok);
    imem_rvalid = pend_valid && rsp_ok;
    imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    imem_gnt    = gnt_ok && imem_req;
    if (imem_rvalid) pend_valid = 1'b0;
    if (imem_gnt) begin
      pend_valid = 1'b1;
      pend_addr  = imem_addr;
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_req, input logic [63:0] e_addr,
                               input logic e_valid, input logic [63:0] e_iaddr);
    check({tag, " imem_req"}, {63'd0, imem_req}, {63'd0, e_req});
    check({tag, " imem_addr"}, imem_addr, e_addr);
    check({tag, " inst_valid"}, {63'd0, inst_valid}, {63'd0, e_valid});
    check({tag, " inst_addr"}, inst_addr, e_iaddr);
    check({tag, " inst"}, {32'd0, inst}, {32'd0, e_valid ? mem_word(e_iaddr) : Nop});
  endtask

  typedef struct {
    logic        rdy;
    logic        gnt_ok;
    logic        rsp_ok;
    logic        redir;
    logic [63:0] rpc;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_iaddr;
  } vec_t;

  vec_t vecs[29];

  initial begin
    int n_xfer;
    logic [63:0] exp_addr;
    logic prev_req, prev_gnt;
    logic [63:0] prev_addr;

    // rdy gnt rsp redir rpc | req addr valid inst_addr (sampled before the row's inputs act)
    vecs[0]  = '{1, 1, 1, 0, 0, 1, A,         0, 0};
    vecs[1]  = '{1, 1, 1, 0, 0, 0, A + 4,     0, 0};
    vecs[2]  = '{1, 1, 1, 0, 0, 1, A + 4,     1, A};
    vecs[3]  = '{1, 1, 1, 0, 0, 0, A + 8,     0, 0};
    // Back-pressure: OR keeps A+4, SB fills with A+8, requests stop.
    vecs[4]  = '{0, 1, 1, 0, 0, 1, A + 8,     1, A + 4};
    vecs[5]  = '{0, 1, 1, 0, 0, 0, A + 12,    1, A + 4};
    vecs[6]  = '{0, 1, 1, 0, 0, 0, A + 12,    1, A + 4};
    vecs[7]  = '{0, 1, 1, 0, 0, 0, A + 12,    1, A + 4};
    vecs[8]  = '{0, 1, 1, 0, 0, 0, A + 12,    1, A + 4};
    vecs[9]  = '{0, 1, 1, 0, 0, 0, A + 12,    1, A + 4};
    // Release: transfers on two consecutive cycles.
    vecs[10] = '{1, 1, 1, 0, 0, 0, A + 12,    1, A + 4};
    vecs[11] = '{1, 1, 1, 0, 0, 1, A + 12,    1, A + 8};
    vecs[12] = '{1, 1, 1, 0, 0, 0, A + 16,    0, 0};
    vecs[13] = '{1, 1, 1, 0, 0, 1, A + 16,    1, A + 12};
    // Redirect in WAIT with the response late: it is dropped.
    vecs[14] = '{1, 1, 0, 1, 64'h8000_0103, 0, A + 20, 0, 0};
    vecs[15] = '{1, 1, 1, 0, 0, 0, B,         0, 0};
    vecs[16] = '{1, 1, 1, 0, 0, 1, B,         0, 0};
    vecs[17] = '{1, 1, 1, 0, 0, 0, B + 4,     0, 0};
    // Redirect in REQ with grant withheld, consumed instruction in the same cycle.
    vecs[18] = '{1, 0, 1, 1, C, 1, B + 4,     1, B};
    vecs[19] = '{1, 1, 1, 0, 0, 0, C,         0, 0};
    vecs[20] = '{1, 0, 1, 0, 0, 1, C,         0, 0};
    vecs[21] = '{1, 1, 1, 0, 0, 1, C,         0, 0};
    // Redirect and response together, target at the top of the address space.
    vecs[22] = '{1, 1, 1, 1, W, 0, C + 4,     0, 0};
    vecs[23] = '{1, 1, 1, 0, 0, 1, W,         0, 0};
    vecs[24] = '{1, 1, 1, 0, 0, 0, 0,         0, 0};
    vecs[25] = '{1, 1, 1, 0, 0, 1, 0,         1, W};
    vecs[26] = '{1, 1, 1, 0, 0, 0, 4,         0, 0};
    vecs[27] = '{0, 1, 1, 0, 0, 1, 4,         1, 0};
    vecs[28] = '{0, 1, 0, 0, 0, 0, 8,         1, 0};

    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_outputs("reset", 1'b0, ResetPc, 1'b0, 64'd0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 29; i++) begin
      check_outputs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_iaddr);
      id_ready       = vecs[i].rdy;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      mem_drive(vecs[i].gnt_ok, vecs[i].rsp_ok);
      @(negedge clk);
    end

    // Reset while a request is outstanding and the output slot is full.
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    rst = 1'b1;
    mem_drive(1'b0, 1'b0);
    @(negedge clk);
    check_outputs("reset_mid_wait", 1'b0, ResetPc, 1'b0, 64'd0);
    pend_valid = 1'b0;  // the old response is never delivered
    rst = 1'b0;
    #1;
    check({"post_reset imem_req"}, {63'd0, imem_req}, 64'd1);
    check({"post_reset imem_addr"}, imem_addr, ResetPc);

    // Random traffic against the instruction-stream model.
    exp_addr = ResetPc;
    n_xfer = 0;
    prev_req = 1'b0;
    prev_gnt = 1'b0;
    prev_addr = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!inst_valid) begin
        check("rand idle inst", {32'd0, inst}, {32'd0, Nop});
        check("rand idle inst_addr", inst_addr, 64'd0);
      end
      if (prev_req && !prev_gnt && imem_req) check("rand addr stable", imem_addr, prev_addr);
      if (imem_req && pend_valid) check("rand single outstanding", 64'd1, 64'd0);

      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = {$urandom, $urandom};
      mem_drive($urandom_range(0, 1) == 1, $urandom_range(0, 4) < 3);

      if (inst_valid && id_ready) begin
        check("rand inst_addr", inst_addr, exp_addr);
        check("rand inst", {32'd0, inst}, {32'd0, mem_word(exp_addr)});
        exp_addr = exp_addr + 64'd4;
        n_xfer++;
      end
      if (redirect_valid) exp_addr = {redirect_pc[63:2], 2'b00};

      prev_req  = imem_req;
      prev_gnt  = imem_gnt;
      prev_addr = imem_addr;
      @(negedge clk);
    end
    check("rand throughput floor", {63'd0, n_xfer > 200}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
